// File: rtl/ysyx_23060180_mc_core.sv
// ysyx_23060180_mc_core: multi-cycle RV32I/RV32E core with a single valid/ready memory port.
module ysyx_23060180_mc_core #(
  parameter logic [31:0] RESET_PC        = 32'h80000000,
  parameter int          NR_REGS         = 32,
  parameter int          RST_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halt,
  output logic        trap_illegal
);
  localparam int RW = $clog2(NR_REGS);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_e;
  logic [RST_SYNC_STAGES-1:0] sync_q, sync_d;
  logic rst_n;
  assign sync_d = RST_SYNC_STAGES'({sync_q, 1'b1});
  assign rst_n  = sync_q[RST_SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rstn_in)
    if (!rstn_in) sync_q <= '0;
    else sync_q <= sync_d;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d, npc_q, npc_d, addr_q, addr_d, retire_pc_q, retire_pc_d;
  logic retire_q, retire_d, trap_q, trap_d, rf_we;
  logic [31:0] regs_q [NR_REGS];

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign f3  = instr_q[14:12];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign f7  = instr_q[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_ebreak;
  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_br     = opc == 7'b1100011;
  assign is_ld     = opc == 7'b0000011;
  assign is_st     = opc == 7'b0100011;
  assign is_opi    = opc == 7'b0010011;
  assign is_op     = opc == 7'b0110011;
  assign is_ebreak = instr_q == 32'h00100073;

  logic legal, use_rd, use_rs1, use_rs2, bad_reg, illegal;
  assign legal = is_lui | is_auipc | is_jal | is_ebreak
    | (is_jalr & f3 == 3'b000)
    | (is_br & f3[2:1] != 2'b01)
    | (is_ld & f3 != 3'b011 & f3[2:1] != 2'b11)
    | (is_st & !f3[2] & f3[1:0] != 2'b11)
    | (is_opi & (f3[1:0] != 2'b01 | f7 == 7'b0000000 | (f3[2] & f7 == 7'b0100000)))
    | (is_op & (f7 == 7'b0000000 | (f7 == 7'b0100000 & (f3 == 3'b000 | f3 == 3'b101))));
  assign use_rd  = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op;
  assign use_rs1 = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
  assign use_rs2 = is_br | is_st | is_op;
  assign bad_reg = (use_rd & 32'(rd) >= 32'(NR_REGS)) | (use_rs1 & 32'(rs1) >= 32'(NR_REGS))
    | (use_rs2 & 32'(rs2) >= 32'(NR_REGS));
  assign illegal = !legal | bad_reg;

  function automatic logic [31:0] rf(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : regs_q[i[RW-1:0]];
  endfunction

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'd0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  logic [31:0] opb, alu, sra, ea, res_ex, npc_ex, ld_sh, ld_val;
  logic [4:0] sh;
  logic taken, misal;
  assign opb = is_op ? b_q : imm_i;
  assign sh  = opb[4:0];
  assign sra = $signed(a_q) >>> sh;
  always_comb
    case (f3)
      3'b000:  alu = (is_op & f7[5]) ? a_q - opb : a_q + opb;
      3'b001:  alu = a_q << sh;
      3'b010:  alu = {31'd0, $signed(a_q) < $signed(opb)};
      3'b011:  alu = {31'd0, a_q < opb};
      3'b100:  alu = a_q ^ opb;
      3'b101:  alu = f7[5] ? sra : a_q >> sh;
      3'b110:  alu = a_q | opb;
      default: alu = a_q & opb;
    endcase
  assign taken  = f3[0] ^ (f3[2] ? (f3[1] ? a_q < b_q : $signed(a_q) < $signed(b_q)) : a_q == b_q);
  assign ea     = a_q + (is_st ? imm_s : imm_i);
  assign misal  = (f3[1:0] == 2'b01 & ea[0]) | (f3[1:0] == 2'b10 & ea[1:0] != 2'b00);
  assign res_ex = is_lui ? imm_u : is_auipc ? pc_q + imm_u : (is_jal | is_jalr) ? pc_q + 32'd4 : alu;
  assign npc_ex = is_jal ? pc_q + imm_j : is_jalr ? (a_q + imm_i) & ~32'd1
                : (is_br & taken) ? pc_q + imm_b : pc_q + 32'd4;
  assign ld_sh  = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ld_val = f3[1] ? ld_sh : f3[0] ? {{16{~f3[2] & ld_sh[15]}}, ld_sh[15:0]}
                : {{24{~f3[2] & ld_sh[7]}}, ld_sh[7:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    npc_d       = npc_q;
    addr_d      = addr_q;
    trap_d      = trap_q;
    retire_d    = 1'b0;
    retire_pc_d = retire_pc_q;
    rf_we       = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (mem_ready) begin
        instr_d = mem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rf(rs1);
        b_d     = rf(rs2);
        trap_d  = illegal;
        state_d = (illegal | is_ebreak) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        res_d   = res_ex;
        npc_d   = npc_ex;
        addr_d  = ea;
        trap_d  = (is_ld | is_st) & misal;
        state_d = (is_ld | is_st) ? (misal ? HALT : MEM) : WRITEBACK;
      end
      MEM: if (mem_ready) begin
        res_d   = is_ld ? ld_val : res_q;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        rf_we       = use_rd & rd != 5'd0;
        pc_d        = npc_q;
        retire_d    = 1'b1;
        retire_pc_d = pc_q;
        state_d     = FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      npc_q       <= '0;
      addr_q      <= '0;
      trap_q      <= 1'b0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      npc_q       <= npc_d;
      addr_q      <= addr_d;
      trap_q      <= trap_d;
      retire_q    <= retire_d;
      retire_pc_q <= retire_pc_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
    else if (rf_we) regs_q[rd[RW-1:0]] <= res_q;

  assign mem_req      = state_q == FETCH | state_q == MEM;
  assign mem_we       = state_q == MEM & is_st;
  assign mem_addr     = state_q == FETCH ? pc_q : addr_q;
  assign mem_wdata    = f3[1] ? b_q : f3[0] ? {2{b_q[15:0]}} : {4{b_q[7:0]}};
  assign mem_wstrb    = mem_we ? (f3[1] ? 4'hF : (f3[0] ? 4'b0011 : 4'b0001) << addr_q[1:0]) : 4'h0;
  assign retire       = retire_q;
  assign retire_pc    = retire_pc_q;
  assign halt         = state_q == HALT;
  assign trap_illegal = trap_q;
endmodule

// File: tb/tb_ysyx_23060180_mc_core.sv
// tb_ysyx_23060180_mc_core: directed programs against a variable-latency memory model with
// queued expectations for retired PCs, fetch addresses and store requests.
module tb_ysyx_23060180_mc_core;
  logic clk = 1'b0, rstn_in = 1'b0;
  logic mem_req, mem_we, mem_ready, retire, halt, trap_illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;
  logic [3:0] mem_wstrb;
  logic r16_req, r16_we, r16_retire, r16_halt, r16_trap;
  logic [31:0] r16_addr, r16_wdata, r16_rpc;
  logic [3:0] r16_wstrb;
  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int flat = 0, dlat = 0, wcnt = 0, cyc = 0, n_chk = 0, n_fail = 0, n_ret = 0, n_ret16 = 0;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} st_t;
  logic [31:0] exp_ret[$], exp_fetch[$];
  st_t exp_st[$];
  int rcyc[$];
  localparam logic [31:0] B = 32'h80000000, EBREAK = 32'h00100073;

  ysyx_23060180_mc_core dut (
    .clk(clk), .rstn_in(rstn_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .retire(retire), .retire_pc(retire_pc), .halt(halt), .trap_illegal(trap_illegal)
  );

  ysyx_23060180_mc_core #(.NR_REGS(16)) dut16 (
    .clk(clk), .rstn_in(rstn_in), .mem_req(r16_req), .mem_we(r16_we), .mem_addr(r16_addr),
    .mem_wdata(r16_wdata), .mem_wstrb(r16_wstrb), .mem_ready(r16_req), .mem_rdata(32'h00100893),
    .retire(r16_retire), .retire_pc(r16_rpc), .halt(r16_halt), .trap_illegal(r16_trap)
  );

  always #5 clk = ~clk;

  // Instruction space answers after flat waits, low data space after dlat waits
  assign mem_ready = mem_req && wcnt >= (mem_addr[31] ? flat : dlat);
  assign mem_rdata = mem_addr[31] ? imem[mem_addr[9:2]] : dmem[mem_addr[7:2]];

  always @(posedge clk or negedge rstn_in)
    if (!rstn_in) wcnt <= 0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ready && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) dmem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    st_t e;
    if (rstn_in) begin
      if (retire) begin
        n_ret++;
        rcyc.push_back(cyc);
        chk("retire_pc", retire_pc, exp_ret.size() > 0 ? exp_ret.pop_front() : 32'hDEADBEEF);
      end
      if (mem_req && mem_we) begin
        e = exp_st.size() > 0 ? exp_st[0] : '1;
        chk("st_addr", mem_addr, e.addr);
        chk("st_data", mem_wdata, e.data);
        chk("st_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
        if (mem_ready && exp_st.size() > 0) void'(exp_st.pop_front());
      end
      if (mem_req && mem_ready && !mem_we && mem_addr[31])
        chk("fetch_addr", mem_addr, exp_fetch.size() > 0 ? exp_fetch.pop_front() : 32'hDEADBEEF);
    end
  end

  always @(negedge clk) if (rstn_in && r16_retire) n_ret16++;

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFFFFFF;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    exp_ret.delete();
    exp_fetch.delete();
    exp_st.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {23'd0, mem_req, mem_we, mem_wstrb, retire, halt, trap_illegal}, 32'd0);
    @(negedge clk);
    rcyc.delete();
    rstn_in = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halt && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halt}, 32'd1);
  endtask

  task automatic wait_req(output int c);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, 32'(exp_ret.size() + exp_fetch.size() + exp_st.size()), 32'd0);
  endtask

  initial begin
    int c0, r0;
    // A: addi/add with zero-wait memory, result stored to 0x40
    clear_imem();
    imem[0] = 32'h00500093;
    imem[1] = 32'h00108133;
    imem[2] = 32'h04202023;
    imem[3] = EBREAK;
    do_reset();
    exp_ret = '{B, B + 4, B + 8};
    exp_fetch = '{B, B + 4, B + 8, B + 12};
    exp_st.push_back('{32'h40, 32'd10, 4'hF});
    wait_req(c0);
    wait_halt("A_halt");
    chk("A_trap", {31'd0, trap_illegal}, 32'd0);
    chk("A_retire_cyc0", 32'(rcyc[0] - c0), 32'd4);
    chk("A_retire_cyc1", 32'(rcyc[1] - c0), 32'd8);
    chk_empty("A_pending");
    // B: store then signed byte load with 3 data wait cycles
    clear_imem();
    imem[0] = 32'h0F600113;
    imem[1] = 32'h00202423;
    imem[2] = 32'h00800183;
    imem[3] = 32'h04302223;
    imem[4] = EBREAK;
    dlat = 3;
    do_reset();
    exp_ret = '{B, B + 4, B + 8, B + 12};
    exp_fetch = '{B, B + 4, B + 8, B + 12, B + 16};
    exp_st.push_back('{32'h8, 32'h000000F6, 4'hF});
    exp_st.push_back('{32'h44, 32'hFFFFFFF6, 4'hF});
    wait_halt("B_halt");
    chk("B_lb_latency", 32'(rcyc[2] - rcyc[1]), 32'd8);
    chk_empty("B_pending");
    dlat = 0;
    // C: jal, taken beq, jal back with link, jalr with odd target
    clear_imem();
    imem[0]  = 32'h0100006F;
    imem[4]  = 32'h00000863;
    imem[8]  = 32'h0E00006F;
    imem[64] = 32'hFF9FF0EF;
    imem[62] = 32'h04102423;
    imem[63] = 32'h00308067;
    imem[65] = EBREAK;
    do_reset();
    exp_ret = '{B, B + 32'h10, B + 32'h20, B + 32'h100, B + 32'hF8, B + 32'hFC};
    exp_fetch = '{B, B + 32'h10, B + 32'h20, B + 32'h100, B + 32'hF8, B + 32'hFC, B + 32'h106};
    exp_st.push_back('{32'h48, 32'h80000104, 4'hF});
    wait_halt("C_halt");
    chk("C_trap", {31'd0, trap_illegal}, 32'd0);
    chk_empty("C_pending");
    // D: not-taken bne falls through
    clear_imem();
    imem[0] = 32'h0100006F;
    imem[4] = 32'h00001863;
    imem[5] = EBREAK;
    do_reset();
    exp_ret = '{B, B + 32'h10};
    exp_fetch = '{B, B + 32'h10, B + 32'h14};
    wait_halt("D_halt");
    chk_empty("D_pending");
    // E: all-ones word is illegal
    clear_imem();
    do_reset();
    r0 = n_ret;
    exp_fetch = '{B};
    wait_halt("E_halt");
    chk("E_trap", {31'd0, trap_illegal}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("E_req_idle", {31'd0, mem_req}, 32'd0);
    end
    chk("E_no_retire", 32'(n_ret - r0), 32'd0);
    chk_empty("E_pending");
    // F: reset pulled while a slow fetch is outstanding
    clear_imem();
    imem[0] = EBREAK;
    flat = 5;
    do_reset();
    wait_req(c0);
    repeat (2) @(negedge clk);
    chk("F_req_pending", {31'd0, mem_req}, 32'd1);
    #2 rstn_in = 1'b0;
    #1 chk("F_req_drop", {31'd0, mem_req}, 32'd0);
    do_reset();
    exp_fetch = '{B};
    wait_halt("F_halt");
    chk("F_trap", {31'd0, trap_illegal}, 32'd0);
    chk_empty("F_pending");
    // RV32E instance fetching addi x17,x0,1 every time
    chk("E16_trap", {31'd0, r16_trap}, 32'd1);
    chk("E16_halt", {31'd0, r16_halt}, 32'd1);
    chk("E16_no_retire", 32'(n_ret16), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
